// File: rtl/demux_pkg.sv
// demux_pkg: shared constants for the 64-bit stream demultiplexer.
// Channel select encodings, default geometry and counter width.
package demux_pkg;

    localparam int DEF_WIDTH = 64;
    localparam int DEF_DEPTH = 2;
    localparam int CNT_W     = 32;

    localparam logic SEL_A = 1'b0;
    localparam logic SEL_B = 1'b1;

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo: per-channel FIFO with registered full/empty flags.
// Head word is always presented on dout; push when full is ignored.
module demux_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULLV = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wptr;
    logic [PW-1:0]    rptr;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rptr];

    // next occupancy: push and pop together leave it unchanged
    always_comb begin
        cnt_nxt = cnt;
        unique case ({do_push, do_pop})
            2'b10:   cnt_nxt = cnt + CW'(1);
            2'b01:   cnt_nxt = cnt - CW'(1);
            default: cnt_nxt = cnt;
        endcase
    end

    // storage, pointers and flags; reset drops all contents
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wptr  <= '0;
            rptr  <= '0;
            cnt   <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            if (do_push) begin
                mem[wptr] <= din;
                wptr      <= wptr + PW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + PW'(1);
            end
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == FULLV);
            empty <= (cnt_nxt == '0);
        end
    end

endmodule

// File: rtl/demux_stream_64.sv
// demux_stream_64: steers one valid/ready stream into channels A/B.
// Optional accepted-word counters enabled by DEMUX_STATS_EN.
module demux_stream_64
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [WIDTH-1:0] In_Data,
    input  logic             In_Select,
    input  logic             In_Valid,
    output logic             In_Ready,
    output logic [WIDTH-1:0] A_Data,
    output logic             A_Valid,
    input  logic             A_Ready,
    output logic [WIDTH-1:0] B_Data,
    output logic             B_Valid,
    input  logic             B_Ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] Count_A,
    output logic [CNT_W-1:0] Count_B
`endif
);

    logic a_full;
    logic a_empty;
    logic b_full;
    logic b_empty;
    logic accept;
    logic a_push;
    logic b_push;
    logic a_pop;
    logic b_pop;

    assign In_Ready = (In_Select == SEL_B) ? ~b_full : ~a_full;
    assign accept   = In_Valid & In_Ready;
    assign a_push   = accept & (In_Select == SEL_A);
    assign b_push   = accept & (In_Select == SEL_B);
    assign A_Valid  = ~a_empty;
    assign B_Valid  = ~b_empty;
    assign a_pop    = A_Valid & A_Ready;
    assign b_pop    = B_Valid & B_Ready;

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_a (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (a_push),
        .pop     (a_pop),
        .din     (In_Data),
        .dout    (A_Data),
        .full    (a_full),
        .empty   (a_empty)
    );

    demux_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo_b (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .push    (b_push),
        .pop     (b_pop),
        .din     (In_Data),
        .dout    (B_Data),
        .full    (b_full),
        .empty   (b_empty)
    );

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_a;
    logic [CNT_W-1:0] cnt_b;

    assign Count_A = cnt_a;
    assign Count_B = cnt_b;

    // count accepted words per channel, wrapping at the top
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_a <= '0;
            cnt_b <= '0;
        end else begin
            if (a_push) cnt_a <= cnt_a + CNT_W'(1);
            if (b_push) cnt_b <= cnt_b + CNT_W'(1);
        end
    end
`endif

endmodule
